// File: rtl/ifetch_bus_pkg.sv
// Shared types and constants for the instruction-fetch bus master.
package ifetch_pkg;

    // Legacy state encodings; the enum below is bound to these values.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        ADDR  = S_ADDR,
        DATA  = S_DATA,
        RESP  = S_RESP,
        DRAIN = S_DRAIN
    } state_e;

    localparam logic [1:0] FE_OK       = 2'b00;
    localparam logic [1:0] FE_MISALIGN = 2'b01;
    localparam logic [1:0] FE_BUSERR   = 2'b10;
    localparam logic [1:0] FE_TIMEOUT  = 2'b11;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifetch_bus_if.sv
// Single-beat AXI4-Lite-style read channel used by the fetch bus master.
interface ifetch_bus_if;

    logic [63:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ifetch_bus.sv
// Instruction-fetch bus master: one 64-bit read per fetch, returns the selected
// 32-bit word with a one-cycle update strobe; faults are turned into a NOP.
module ifetch_bus
    import ifetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] NOP_INSTR   = RV_NOP
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_en,
    input  logic [63:0] pc,
    output logic [31:0] instr,
    output logic        update,
    output logic [1:0]  fetch_err,
    output logic        busy,
    ifetch_bus_if.master bus
);

    localparam int unsigned    CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state;
    logic             req_sel;
    logic             drain_pending;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      araddr_q;
    logic             arvalid_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            instr         <= NOP_INSTR;
            fetch_err     <= FE_OK;
            araddr_q      <= '0;
            arvalid_q     <= 1'b0;
            cnt           <= '0;
            req_sel       <= 1'b0;
            drain_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        if (pc[1:0] == 2'b00) begin
                            req_sel   <= pc[2];
                            araddr_q  <= {pc[63:3], 3'b000};
                            arvalid_q <= 1'b1;
                            state     <= ADDR;
                        end else begin
                            instr         <= NOP_INSTR;
                            fetch_err     <= FE_MISALIGN;
                            drain_pending <= 1'b0;
                            state         <= RESP;
                        end
                    end
                end
                ADDR: begin
                    // arvalid is always high here, so arready alone completes the handshake.
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        cnt       <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bus.rvalid) begin
                        if (bus.rresp == 2'b00) begin
                            instr     <= req_sel ? bus.rdata[63:32] : bus.rdata[31:0];
                            fetch_err <= FE_OK;
                        end else begin
                            instr     <= NOP_INSTR;
                            fetch_err <= FE_BUSERR;
                        end
                        drain_pending <= 1'b0;
                        state         <= RESP;
                    end else if (cnt == CNT_MAX) begin
                        instr         <= NOP_INSTR;
                        fetch_err     <= FE_TIMEOUT;
                        drain_pending <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= drain_pending ? DRAIN : IDLE;
                end
                DRAIN: begin
                    // The late response of a timed-out read is swallowed here.
                    if (bus.rvalid) begin
                        drain_pending <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign update      = (state == RESP);
    assign busy        = (state != IDLE);
    assign bus.araddr  = araddr_q;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = (state == DATA) || (state == DRAIN);

endmodule

// File: tb/tb_ifetch_bus.sv
// Directed self-checking bench for ifetch_bus with TIMEOUT_CYC=8.
module tb_ifetch_bus;

    logic        clk;
    logic        rstn;
    logic        fetch_en;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        update;
    logic [1:0]  fetch_err;
    logic        busy;

    int compared;
    int mismatched;
    int cyc;

    ifetch_bus_if bus ();

    ifetch_bus #(.TIMEOUT_CYC(8), .NOP_INSTR(32'h0000_0013)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .fetch_en  (fetch_en),
        .pc        (pc),
        .instr     (instr),
        .update    (update),
        .fetch_err (fetch_err),
        .busy      (busy),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_fetch(input string tag, input logic [63:0] p, input logic [63:0] exp_addr,
                             input int ar_wait, input logic [63:0] d, input logic [1:0] resp,
                             input logic [31:0] exp_instr, input logic [1:0] exp_err,
                             input int exp_lat);
        int t0;
        t0 = cyc;
        fetch_en    = 1'b1;
        pc          = p;
        bus.arready = (ar_wait == 0);
        step;
        fetch_en = 1'b0;
        pc       = ~p;
        chk({tag, ".arvalid"}, 64'(bus.arvalid), 64'd1);
        chk({tag, ".araddr"}, bus.araddr, exp_addr);
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        for (int i = 0; i < ar_wait; i++) begin
            step;
            chk({tag, ".arvalid_hold"}, 64'(bus.arvalid), 64'd1);
            chk({tag, ".araddr_hold"}, bus.araddr, exp_addr);
        end
        bus.arready = 1'b1;
        step;
        bus.arready = 1'b0;
        chk({tag, ".arvalid_drop"}, 64'(bus.arvalid), 64'd0);
        chk({tag, ".rready"}, 64'(bus.rready), 64'd1);
        chk({tag, ".no_early_update"}, 64'(update), 64'd0);
        bus.rvalid = 1'b1;
        bus.rdata  = d;
        bus.rresp  = resp;
        step;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        bus.rresp  = 2'b00;
        chk({tag, ".update"}, 64'(update), 64'd1);
        chk({tag, ".instr"}, 64'(instr), 64'(exp_instr));
        chk({tag, ".fetch_err"}, 64'(fetch_err), 64'(exp_err));
        chk({tag, ".rready_resp"}, 64'(bus.rready), 64'd0);
        chk({tag, ".latency"}, 64'(cyc - t0), 64'(exp_lat));
        step;
        chk({tag, ".update_single"}, 64'(update), 64'd0);
        chk({tag, ".idle"}, 64'(busy), 64'd0);
        chk({tag, ".instr_hold"}, 64'(instr), 64'(exp_instr));
        chk({tag, ".err_hold"}, 64'(fetch_err), 64'(exp_err));
    endtask

    initial begin
        int t0;
        compared    = 0;
        mismatched  = 0;
        cyc         = 0;
        rstn        = 1'b0;
        fetch_en    = 1'b0;
        pc          = '0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;

        step;
        step;
        chk("rst.instr", 64'(instr), 64'h13);
        chk("rst.update", 64'(update), 64'd0);
        chk("rst.fetch_err", 64'(fetch_err), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.arvalid", 64'(bus.arvalid), 64'd0);
        chk("rst.rready", 64'(bus.rready), 64'd0);
        chk("rst.araddr", bus.araddr, 64'd0);
        rstn = 1'b1;
        step;

        // Stray rvalid while idle must be ignored.
        bus.rvalid = 1'b1;
        step;
        bus.rvalid = 1'b0;
        chk("stray.rready", 64'(bus.rready), 64'd0);
        chk("stray.busy", 64'(busy), 64'd0);
        chk("stray.update", 64'(update), 64'd0);

        run_fetch("aligned", 64'h8000_0000, 64'h8000_0000, 0, 64'hDEADBEEF_00000413, 2'b00,
                  32'h0000_0413, 2'b00, 3);
        run_fetch("upper", 64'h8000_0004, 64'h8000_0000, 0, 64'hDEADBEEF_00000413, 2'b00,
                  32'hDEAD_BEEF, 2'b00, 3);
        run_fetch("bkpr", 64'h8000_0104, 64'h8000_0100, 3, 64'h12345678_9ABCDEF0, 2'b00,
                  32'h1234_5678, 2'b00, 6);
        run_fetch("buserr", 64'h8000_000C, 64'h8000_0008, 0, 64'hCAFEF00D_11111111, 2'b10,
                  32'h0000_0013, 2'b10, 3);

        // Misaligned PC: no bus activity, strobe one cycle later.
        t0       = cyc;
        fetch_en = 1'b1;
        pc       = 64'h8000_0002;
        step;
        fetch_en = 1'b0;
        chk("mis.update", 64'(update), 64'd1);
        chk("mis.fetch_err", 64'(fetch_err), 64'd1);
        chk("mis.instr", 64'(instr), 64'h13);
        chk("mis.arvalid", 64'(bus.arvalid), 64'd0);
        chk("mis.latency", 64'(cyc - t0), 64'd1);
        step;
        chk("mis.update_single", 64'(update), 64'd0);
        chk("mis.idle", 64'(busy), 64'd0);
        chk("mis.arvalid_after", 64'(bus.arvalid), 64'd0);

        // Timeout: 8 DATA cycles without rvalid, then drain a late response.
        t0          = cyc;
        fetch_en    = 1'b1;
        pc          = 64'h8000_0020;
        bus.arready = 1'b1;
        step;
        fetch_en = 1'b0;
        chk("to.arvalid", 64'(bus.arvalid), 64'd1);
        step;
        bus.arready = 1'b0;
        chk("to.rready", 64'(bus.rready), 64'd1);
        for (int i = 0; i < 7; i++) begin
            step;
            chk("to.wait_update", 64'(update), 64'd0);
        end
        step;
        chk("to.update", 64'(update), 64'd1);
        chk("to.fetch_err", 64'(fetch_err), 64'd3);
        chk("to.instr", 64'(instr), 64'h13);
        chk("to.latency", 64'(cyc - t0), 64'd10);
        step;
        chk("drain.rready", 64'(bus.rready), 64'd1);
        chk("drain.busy", 64'(busy), 64'd1);
        chk("drain.update", 64'(update), 64'd0);
        fetch_en = 1'b1;
        pc       = 64'h8000_0040;
        step;
        step;
        chk("drain.no_arvalid", 64'(bus.arvalid), 64'd0);
        chk("drain.still_busy", 64'(busy), 64'd1);
        fetch_en   = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = 64'h55555555_66666666;
        step;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        chk("drain.done_idle", 64'(busy), 64'd0);
        chk("drain.no_update", 64'(update), 64'd0);
        chk("drain.instr_hold", 64'(instr), 64'h13);
        chk("drain.err_hold", 64'(fetch_err), 64'd3);
        step;
        chk("drain.no_new_ar", 64'(bus.arvalid), 64'd0);

        // rvalid on the terminal-count cycle wins over the timeout.
        fetch_en    = 1'b1;
        pc          = 64'h8000_0034;
        bus.arready = 1'b1;
        step;
        fetch_en = 1'b0;
        step;
        bus.arready = 1'b0;
        for (int i = 0; i < 7; i++) step;
        bus.rvalid = 1'b1;
        bus.rdata  = 64'hA5A5A5A5_5A5A5A5A;
        step;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        chk("tc.update", 64'(update), 64'd1);
        chk("tc.fetch_err", 64'(fetch_err), 64'd0);
        chk("tc.instr", 64'(instr), 64'hA5A5A5A5);
        step;
        chk("tc.no_drain", 64'(busy), 64'd0);
        chk("tc.rready", 64'(bus.rready), 64'd0);

        // Asynchronous reset in the middle of DATA.
        fetch_en    = 1'b1;
        pc          = 64'h8000_0048;
        bus.arready = 1'b1;
        step;
        fetch_en = 1'b0;
        step;
        bus.arready = 1'b0;
        chk("arst.pre_rready", 64'(bus.rready), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst.rready", 64'(bus.rready), 64'd0);
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.update", 64'(update), 64'd0);
        chk("arst.instr", 64'(instr), 64'h13);
        chk("arst.fetch_err", 64'(fetch_err), 64'd0);
        chk("arst.araddr", bus.araddr, 64'd0);
        chk("arst.arvalid", 64'(bus.arvalid), 64'd0);
        step;
        rstn = 1'b1;
        step;
        chk("arst.idle", 64'(busy), 64'd0);

        run_fetch("post_rst", 64'h0000_1000, 64'h0000_1000, 1, 64'h00000000_00100093, 2'b00,
                  32'h0010_0093, 2'b00, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
